// File: rtl/pipe_buffer_pkg.sv
// rtl/pipe_buffer_pkg.sv - shared defaults and width helper for the pipe buffer
package pipe_buffer_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int DEPTH_DEF  = 2;

   // Ceiling log2; a depth of 1 still gets a one-bit pointer.
   function automatic int clog2(input int value);
      int w;
      w = 0;
      while ((1 << w) < value) begin
         w = w + 1;
      end
      if (w == 0) begin
         w = 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/pipe_buffer_ram.sv
// rtl/pipe_buffer_ram.sv - entry storage: one write port, one asynchronous read port, no reset
module pipe_buffer_ram
   import pipe_buffer_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = DEPTH_DEF,
   parameter int AW     = clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [AW-1:0]     waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [AW-1:0]     raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pipe_buffer.sv
// rtl/pipe_buffer.sv - valid/ready FIFO buffer; all flags decoded from registered count
module pipe_buffer
   import pipe_buffer_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = DEPTH_DEF,
   parameter int AW     = clog2(DEPTH),
   parameter int CW     = clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CW-1:0]     count
);

   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic [DATA_W-1:0] rdata;
   logic              push, pop;

   assign in_ready  = (count_q < CW'(DEPTH));
   assign out_valid = (count_q != '0);
   assign push      = in_valid & in_ready & ~flush;
   assign pop       = out_valid & out_ready & ~flush;

   pipe_buffer_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) u_ram (
      .clk     (clk),
      .we_i    (push),
      .waddr_i (wr_ptr_q),
      .wdata_i (in_data),
      .raddr_i (rd_ptr_q),
      .rdata_o (rdata)
   );

   // Power-of-two depth lets the pointers wrap naturally at DEPTH-1.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         if (push && !pop) begin
            count_d = count_q + CW'(1);
         end else if (pop && !push) begin
            count_d = count_q - CW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is never cleared, so gate the head to zero when nothing is stored.
   assign out_data = out_valid ? rdata : '0;
   assign count    = count_q;

endmodule

// File: tb/tb_pipe_buffer.sv
// tb/tb_pipe_buffer.sv - directed vector bench for pipe_buffer at DEPTH 4 and DEPTH 2
module tb_pipe_buffer;

   logic clk;
   logic rst;

   logic        fl4, iv4, or4, ir4, ov4;
   logic [31:0] id4, od4;
   logic [2:0]  cnt4;

   logic        fl2, iv2, or2, ir2, ov2;
   logic [31:0] id2, od2;
   logic [1:0]  cnt2;

   int n_tests;
   int n_fail;

   pipe_buffer #(.DATA_W(32), .DEPTH(4)) u_dut4 (
      .clk       (clk),
      .rst       (rst),
      .flush     (fl4),
      .in_valid  (iv4),
      .in_ready  (ir4),
      .in_data   (id4),
      .out_valid (ov4),
      .out_ready (or4),
      .out_data  (od4),
      .count     (cnt4)
   );

   pipe_buffer #(.DATA_W(32), .DEPTH(2)) u_dut2 (
      .clk       (clk),
      .rst       (rst),
      .flush     (fl2),
      .in_valid  (iv2),
      .in_ready  (ir2),
      .in_data   (id2),
      .out_valid (ov2),
      .out_ready (or2),
      .out_data  (od2),
      .count     (cnt2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        iv;
      logic [31:0] d;
      logic        ordy;
      logic        fl;
      int          cnt;
      logic        ov;
      logic        ir;
      logic [31:0] od;
   } vec_t;

   vec_t vecs [18];

   task automatic check(input string name, input longint act, input longint exp);
      n_tests = n_tests + 1;
      if (act != exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check4(input string tag, input int c, input logic v, input logic r, input logic [31:0] d);
      check({tag, " count"}, cnt4, c);
      check({tag, " out_valid"}, ov4, v);
      check({tag, " in_ready"}, ir4, r);
      check({tag, " out_data"}, od4, d);
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst = 1'b1;
      fl4 = 0; iv4 = 0; or4 = 0; id4 = '0;
      fl2 = 0; iv2 = 0; or2 = 0; id2 = '0;

      vecs[0]  = '{1'b1, 32'hA1, 1'b0, 1'b0, 1, 1'b1, 1'b1, 32'hA1};
      vecs[1]  = '{1'b1, 32'hA2, 1'b0, 1'b0, 2, 1'b1, 1'b1, 32'hA1};
      vecs[2]  = '{1'b1, 32'hA3, 1'b0, 1'b0, 3, 1'b1, 1'b1, 32'hA1};
      vecs[3]  = '{1'b1, 32'hA4, 1'b0, 1'b0, 4, 1'b1, 1'b0, 32'hA1};
      vecs[4]  = '{1'b1, 32'hA5, 1'b0, 1'b0, 4, 1'b1, 1'b0, 32'hA1};
      vecs[5]  = '{1'b0, 32'h00, 1'b1, 1'b0, 3, 1'b1, 1'b1, 32'hA2};
      vecs[6]  = '{1'b0, 32'h00, 1'b1, 1'b0, 2, 1'b1, 1'b1, 32'hA3};
      vecs[7]  = '{1'b0, 32'h00, 1'b1, 1'b0, 1, 1'b1, 1'b1, 32'hA4};
      vecs[8]  = '{1'b0, 32'h00, 1'b1, 1'b0, 0, 1'b0, 1'b1, 32'h00};
      vecs[9]  = '{1'b0, 32'h00, 1'b1, 1'b0, 0, 1'b0, 1'b1, 32'h00};
      vecs[10] = '{1'b0, 32'h00, 1'b1, 1'b0, 0, 1'b0, 1'b1, 32'h00};
      vecs[11] = '{1'b1, 32'hB1, 1'b0, 1'b0, 1, 1'b1, 1'b1, 32'hB1};
      vecs[12] = '{1'b1, 32'hB2, 1'b0, 1'b0, 2, 1'b1, 1'b1, 32'hB1};
      vecs[13] = '{1'b1, 32'hB3, 1'b0, 1'b0, 3, 1'b1, 1'b1, 32'hB1};
      vecs[14] = '{1'b1, 32'hCC, 1'b1, 1'b1, 0, 1'b0, 1'b1, 32'h00};
      vecs[15] = '{1'b1, 32'h11, 1'b0, 1'b0, 1, 1'b1, 1'b1, 32'h11};
      vecs[16] = '{1'b1, 32'h22, 1'b1, 1'b0, 1, 1'b1, 1'b1, 32'h22};
      vecs[17] = '{1'b0, 32'h00, 1'b1, 1'b0, 0, 1'b0, 1'b1, 32'h00};

      #12;
      check4("reset", 0, 1'b0, 1'b1, 32'h0);
      check("reset d2 count", cnt2, 0);
      check("reset d2 in_ready", ir2, 1);
      @(negedge clk);
      rst = 1'b0;

      // Main vector table on the DEPTH=4 instance
      for (int i = 0; i < 18; i++) begin
         iv4 = vecs[i].iv;
         id4 = vecs[i].d;
         or4 = vecs[i].ordy;
         fl4 = vecs[i].fl;
         step();
         check4($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].ov, vecs[i].ir, vecs[i].od);
      end

      // Steady count of 2 with push+pop each cycle, pointers wrap twice
      iv4 = 0; or4 = 0; fl4 = 1;
      step();
      fl4 = 0; iv4 = 1; id4 = 32'h10;
      step();
      id4 = 32'h11;
      step();
      check("hold fill count", cnt4, 2);
      or4 = 1;
      for (int i = 0; i < 8; i++) begin
         id4 = 32'h12 + i;
         step();
         check($sformatf("hold%0d count", i), cnt4, 2);
         check($sformatf("hold%0d data", i), od4, 32'h11 + i);
      end
      iv4 = 0;
      step();
      check("hold drain0 data", od4, 32'h19);
      step();
      check("hold drain1 count", cnt4, 0);
      or4 = 0;

      // Full throughput on the DEPTH=2 instance
      iv2 = 1; or2 = 1;
      for (int k = 1; k <= 10; k++) begin
         id2 = k;
         step();
         check($sformatf("thru%0d data", k), od2, k);
         check($sformatf("thru%0d count", k), cnt2, 1);
      end
      iv2 = 0;
      step();
      check("thru drain count", cnt2, 0);
      or2 = 0;

      // Asynchronous reset between edges with three entries stored
      iv4 = 1;
      for (int k = 0; k < 3; k++) begin
         id4 = 32'hE0 + k;
         step();
      end
      iv4 = 0;
      check("pre-rst count", cnt4, 3);
      #2 rst = 1'b1;
      #1;
      check4("async rst", 0, 1'b0, 1'b1, 32'h0);
      #1 rst = 1'b0;
      iv4 = 1; id4 = 32'h55;
      step();
      iv4 = 0;
      check4("post-rst push", 1, 1'b1, 1'b1, 32'h55);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
